pool_layer_sequencer: RTL
=========================

Name: pool_layer_sequencer

Overview:
Sequences the pooling datapath over a whole pooling layer. It walks one or more square feature maps stored in a single-port pixel memory and assembles each non-overlapping win×win window into a 25-slot window register. That register drives the combinational pooling unit (max/avg, selected by win_size). The block then writes each pooled result to an output memory in row-major order. It sits between the layer controller (start/done handshake) and the pool memory/pool unit.

Parameters:
DATA_W, 16, pixel width (signed fixed point)
ADDR_W, 16, memory address width
IMG_MAX, 32, largest legal img_size
WIN_MAX, 5, largest legal win_size (window register has WIN_MAX*WIN_MAX slots)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to run the layer; sampled only in IDLE
img_size  in  16  feature-map side length
win_size  in  16  pooling window side length
num_maps  in  8  number of feature maps (channels)
in_base  in  ADDR_W  pixel memory base address of map 0
out_base  in  ADDR_W  output memory base address
rd_en  out  1  pixel memory read strobe
rd_addr  out  ADDR_W  pixel read address
rd_data  in  DATA_W  read data, valid exactly 1 cycle after rd_en
window  out  DATA_W*25  window register, slot k at bits [k*DATA_W +: DATA_W]
win_valid  out  1  window register complete this cycle
pool_result  in  DATA_W  combinational result of the pool unit for the current window
wr_en  out  1  output memory write strobe
wr_addr  out  ADDR_W  output write address
wr_data  out  DATA_W  output write data
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse
cfg_err  out  1  configuration rejected; held until next accepted start

Behaviour:
- Reset (synchronous, active-high; clock clk) clears all outputs and internal state:
  - rd_en, rd_addr, wr_en, wr_addr, wr_data, win_valid, busy, done and cfg_err are 0.
  - All window slots are 0. FSM goes to IDLE.
- Reset takes priority over every other event. Asserting it mid-run aborts with no further reads or writes. A read in flight is discarded.
- FSM states: IDLE, LOAD, DRAIN, POOL, FIN.
- Configuration is latched when start is sampled in IDLE. start in any other state is ignored.
- Config is invalid if any of these hold: win_size==0, win_size>WIN_MAX, img_size==0, img_size>IMG_MAX, win_size>img_size, num_maps==0.
- Invalid config: IDLE -> FIN. No rd_en or wr_en is issued; cfg_err is set to 1.
- Valid config: cfg_err is cleared to 0, busy goes to 1, and the FSM enters LOAD.
- Output side od = floor(img_size / win_size). Rows and columns beyond od*win_size are never read.
- Windows are walked in order: map m = 0..num_maps-1, then orow = 0..od-1, then ocol = 0..od-1.
- LOAD: one read per cycle for r = 0..w-1, c = 0..w-1 (row-major), w*w cycles in total.
  - rd_addr = in_base + m*img*img + (orow*w + r)*img + ocol*w + c.
  - Addresses wrap modulo 2^ADDR_W.
- Each rd_data lands in slot k = r*w + c one cycle after its read. Slots k >= w*w are zeroed on the first LOAD cycle of every window.
- DRAIN: one cycle in which the last read datum is captured; no rd_en.
- POOL: one cycle with win_valid=1, wr_en=1, wr_data=pool_result and wr_addr = out_base + m*od*od + orow*od + ocol.
  - Indices advance in this cycle.
  - Next state is LOAD for the next window, or FIN after the last window of the last map.
- Cost per window: w*w + 2 cycles; no idle cycles between windows.
- FIN: done=1 for one cycle, busy=0, then IDLE. The window register keeps the last window until the next start.
- Computed m*img*img and similar products are at least 2*ADDR_W bits wide before truncation.

Test Plan:
- 4×4 map with pixels 0..15, win=2, num_maps=1, in_base=0, out_base=0x100, bench pool model = max:
  - writes 5,7,13,15 to 0x100..0x103;
  - done arrives 24 cycles after the start cycle's successor;
  - win_valid is asserted exactly 4 times.
- img=5, win=2, pixels 0..24: od=2; the bench checks that no rd_addr ever hits row 4 or column 4 (addresses 4, 9, 14, 19, 20..24).
- num_maps=2, img=4, win=4, in_base=0x10, map 1 pixels = 100+i:
  - two writes, at out_base and out_base+1;
  - reads run 0x10..0x1F, then 0x20..0x2F;
  - slots 16..24 read 0 throughout.
- win=6 (>WIN_MAX) or win=0: no rd_en or wr_en; done pulses one cycle after start with cfg_err=1. A following valid start clears cfg_err.
- Assert reset during LOAD of the 2nd window: the next cycle shows all outputs 0 and no wr_en afterwards. A new start reruns from window 0 with the correct results.
- Pulse start while busy (mid-run) with different img_size: ignored; results and cycle count are identical to the undisturbed run.

Source files
------------

// File: rtl/pool_layer_sequencer.sv
// Pooling-layer sequencer: walks square feature maps window by window, fills the
// window register for the external pool unit and writes pooled results row-major.
module pool_layer_sequencer #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned IMG_MAX = 32,
  parameter int unsigned WIN_MAX = 5
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start_i,
  input  logic [15:0]                         img_size_i,
  input  logic [15:0]                         win_size_i,
  input  logic [7:0]                          num_maps_i,
  input  logic [ADDR_W-1:0]                   in_base_i,
  input  logic [ADDR_W-1:0]                   out_base_i,
  output logic                                rd_en_o,
  output logic [ADDR_W-1:0]                   rd_addr_o,
  input  logic [DATA_W-1:0]                   rd_data_i,
  output logic [DATA_W*WIN_MAX*WIN_MAX-1:0]   window_o,
  output logic                                win_valid_o,
  input  logic [DATA_W-1:0]                   pool_result_i,
  output logic                                wr_en_o,
  output logic [ADDR_W-1:0]                   wr_addr_o,
  output logic [DATA_W-1:0]                   wr_data_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                cfg_err_o
);

  localparam int unsigned Slots = WIN_MAX * WIN_MAX;
  localparam int unsigned SlotW = $clog2(Slots);
  localparam int unsigned PW    = 2 * ADDR_W;
  localparam int unsigned ImgW  = $clog2(IMG_MAX + 1);
  localparam int unsigned WinW  = $clog2(WIN_MAX + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StDrain, StPool, StFin} state_e;

  state_e             state_q, state_d;
  logic [15:0]        img_q, img_d, win_q, win_d, od_q, od_d;
  logic [7:0]         maps_q, maps_d, m_q, m_d;
  logic [ADDR_W-1:0]  in_base_q, in_base_d, out_base_q, out_base_d;
  logic [15:0]        orow_q, orow_d, ocol_q, ocol_d, r_q, r_d, c_q, c_d;
  logic               cap_vld_q, cap_vld_d;
  logic [SlotW-1:0]   cap_slot_q, cap_slot_d;
  logic               cfg_err_q, cfg_err_d;
  logic [DATA_W-1:0]  win_regs_q [Slots];

  logic               cfg_bad;
  logic [WinW-1:0]    win_div;
  logic [ImgW-1:0]    od_narrow;
  logic [15:0]        ww;
  logic [PW-1:0]      rd_addr_full, wr_addr_full;

  // Divider only needs the legal operand range; out-of-range configs are rejected anyway.
  always_comb begin
    cfg_bad = (win_size_i == 16'd0) || (win_size_i > 16'(WIN_MAX)) ||
              (img_size_i == 16'd0) || (img_size_i > 16'(IMG_MAX)) ||
              (win_size_i > img_size_i) || (num_maps_i == 8'd0);
    win_div   = (win_size_i[WinW-1:0] == '0) ? WinW'(1) : win_size_i[WinW-1:0];
    od_narrow = img_size_i[ImgW-1:0] / ImgW'(win_div);
    ww        = win_q * win_q;
  end

  always_comb begin
    rd_addr_full = PW'(in_base_q)
                 + PW'(m_q) * PW'(img_q) * PW'(img_q)
                 + (PW'(orow_q) * PW'(win_q) + PW'(r_q)) * PW'(img_q)
                 + PW'(ocol_q) * PW'(win_q) + PW'(c_q);
    wr_addr_full = PW'(out_base_q)
                 + PW'(m_q) * PW'(od_q) * PW'(od_q)
                 + PW'(orow_q) * PW'(od_q) + PW'(ocol_q);
  end

  always_comb begin
    state_d     = state_q;
    img_d       = img_q;
    win_d       = win_q;
    od_d        = od_q;
    maps_d      = maps_q;
    in_base_d   = in_base_q;
    out_base_d  = out_base_q;
    m_d         = m_q;
    orow_d      = orow_q;
    ocol_d      = ocol_q;
    r_d         = r_q;
    c_d         = c_q;
    cap_vld_d   = 1'b0;
    cap_slot_d  = cap_slot_q;
    cfg_err_d   = cfg_err_q;
    rd_en_o     = 1'b0;
    rd_addr_o   = '0;
    win_valid_o = 1'b0;
    wr_en_o     = 1'b0;
    wr_addr_o   = '0;
    wr_data_o   = '0;
    busy_o      = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          img_d      = img_size_i;
          win_d      = win_size_i;
          od_d       = 16'(od_narrow);
          maps_d     = num_maps_i;
          in_base_d  = in_base_i;
          out_base_d = out_base_i;
          m_d        = '0;
          orow_d     = '0;
          ocol_d     = '0;
          r_d        = '0;
          c_d        = '0;
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
            state_d   = StFin;
          end else begin
            cfg_err_d = 1'b0;
            state_d   = StLoad;
          end
        end
      end
      StLoad: begin
        busy_o     = 1'b1;
        rd_en_o    = 1'b1;
        rd_addr_o  = rd_addr_full[ADDR_W-1:0];
        cap_vld_d  = 1'b1;
        cap_slot_d = SlotW'(r_q * win_q + c_q);
        if (c_q == win_q - 16'd1) begin
          c_d = '0;
          if (r_q == win_q - 16'd1) begin
            r_d     = '0;
            state_d = StDrain;
          end else begin
            r_d = r_q + 16'd1;
          end
        end else begin
          c_d = c_q + 16'd1;
        end
      end
      StDrain: begin
        busy_o  = 1'b1;
        state_d = StPool;
      end
      StPool: begin
        busy_o      = 1'b1;
        win_valid_o = 1'b1;
        wr_en_o     = 1'b1;
        wr_addr_o   = wr_addr_full[ADDR_W-1:0];
        wr_data_o   = pool_result_i;
        state_d     = StLoad;
        if (ocol_q == od_q - 16'd1) begin
          ocol_d = '0;
          if (orow_q == od_q - 16'd1) begin
            orow_d = '0;
            if (m_q == maps_q - 8'd1) begin
              state_d = StFin;
            end else begin
              m_d = m_q + 8'd1;
            end
          end else begin
            orow_d = orow_q + 16'd1;
          end
        end else begin
          ocol_d = ocol_q + 16'd1;
        end
      end
      StFin: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      img_q      <= '0;
      win_q      <= '0;
      od_q       <= '0;
      maps_q     <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      m_q        <= '0;
      orow_q     <= '0;
      ocol_q     <= '0;
      r_q        <= '0;
      c_q        <= '0;
      cap_vld_q  <= 1'b0;
      cap_slot_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      img_q      <= img_d;
      win_q      <= win_d;
      od_q       <= od_d;
      maps_q     <= maps_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      m_q        <= m_d;
      orow_q     <= orow_d;
      ocol_q     <= ocol_d;
      r_q        <= r_d;
      c_q        <= c_d;
      cap_vld_q  <= cap_vld_d;
      cap_slot_q <= cap_slot_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Unused slots are cleared on the first read of each window so smaller windows see zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < Slots; k++) win_regs_q[k] <= '0;
    end else begin
      if ((state_q == StLoad) && (r_q == 16'd0) && (c_q == 16'd0)) begin
        for (int k = 0; k < Slots; k++) begin
          if (k >= int'(ww)) win_regs_q[k] <= '0;
        end
      end
      if (cap_vld_q && (int'(cap_slot_q) < Slots)) win_regs_q[cap_slot_q] <= rd_data_i;
    end
  end

  always_comb begin
    window_o = '0;
    for (int k = 0; k < Slots; k++) window_o[k*DATA_W +: DATA_W] = win_regs_q[k];
  end

  assign cfg_err_o = cfg_err_q;

endmodule
